// File: rtl/fp_accumulator.sv
// fp_accumulator: sequential IEEE-754 single-precision accumulator.
// Each accepted term takes four cycles (IDLE, ALIGN, ADD, NORM). The sum is
// presented in OUT when the term flagged last has been added.
module fp_accumulator #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [CNT_W-1:0] out_count
);

  localparam logic [31:0] QNAN = 32'h7FC00000;

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, OUT} state_t;

  state_t           r_state;
  logic             r_inReady;
  logic             r_outValid;
  logic             r_last;
  logic             r_special;
  logic             r_signA;
  logic             r_signB;
  logic             r_sumSign;
  logic [31:0]      r_acc;
  logic [31:0]      r_term;
  logic [31:0]      r_specialVal;
  logic [CNT_W-1:0] r_count;
  logic [23:0]      r_mantA;
  logic [23:0]      r_mantB;
  logic [7:0]       r_exp;
  logic [24:0]      r_sum;

  logic [7:0]  w_expA;
  logic [7:0]  w_expB;
  logic [7:0]  w_diff;
  logic [7:0]  w_maxExp;
  logic [23:0] w_mantA;
  logic [23:0] w_mantB;
  logic [23:0] w_alignA;
  logic [23:0] w_alignB;
  logic        w_nanA;
  logic        w_nanB;
  logic        w_infA;
  logic        w_infB;
  logic        w_special;
  logic [31:0] w_specialVal;
  logic [24:0] w_sum;
  logic        w_sumSign;
  logic [4:0]  w_lzc;
  logic [22:0] w_normMant;
  logic [8:0]  w_expInc;
  logic [7:0]  w_expDec;
  logic [31:0] w_result;

  // Unpack accumulator and term, detect inf/NaN, and align the smaller-exponent mantissa.
  always_comb begin
    w_expA  = r_acc[30:23];
    w_expB  = r_term[30:23];
    w_mantA = (w_expA == 8'd0) ? 24'd0 : {1'b1, r_acc[22:0]};
    w_mantB = (w_expB == 8'd0) ? 24'd0 : {1'b1, r_term[22:0]};
    w_nanA  = (w_expA == 8'hFF) && (r_acc[22:0] != 23'd0);
    w_nanB  = (w_expB == 8'hFF) && (r_term[22:0] != 23'd0);
    w_infA  = (w_expA == 8'hFF) && (r_acc[22:0] == 23'd0);
    w_infB  = (w_expB == 8'hFF) && (r_term[22:0] == 23'd0);
    w_special = w_nanA | w_nanB | w_infA | w_infB;
    if (w_nanA || w_nanB || (w_infA && w_infB && (r_acc[31] != r_term[31])))
      w_specialVal = QNAN;
    else if (w_infA)
      w_specialVal = r_acc;
    else
      w_specialVal = r_term;
    w_alignA = w_mantA;
    w_alignB = w_mantB;
    if (w_expA >= w_expB) begin
      w_maxExp = w_expA;
      w_diff   = w_expA - w_expB;
      w_alignB = (w_diff >= 8'd25) ? 24'd0 : (w_mantB >> w_diff);
    end else begin
      w_maxExp = w_expB;
      w_diff   = w_expB - w_expA;
      w_alignA = (w_diff >= 8'd25) ? 24'd0 : (w_mantA >> w_diff);
    end
  end

  // Signed-magnitude add: larger magnitude minus smaller when the signs differ.
  always_comb begin
    w_sum     = 25'd0;
    w_sumSign = r_signA;
    if (r_signA == r_signB) begin
      w_sum = {1'b0, r_mantA} + {1'b0, r_mantB};
    end else if (r_mantA >= r_mantB) begin
      w_sum     = {1'b0, r_mantA - r_mantB};
      w_sumSign = r_signA;
    end else begin
      w_sum     = {1'b0, r_mantB - r_mantA};
      w_sumSign = r_signB;
    end
  end

  // Normalise the raw sum, then resolve zero, overflow, underflow and inf/NaN results.
  always_comb begin
    w_lzc = 5'd0;
    for (int i = 0; i < 24; i++) begin
      if (r_sum[i]) w_lzc = 5'(23 - i);
    end
    w_expInc   = {1'b0, r_exp} + 9'd1;
    w_expDec   = r_exp - {3'b000, w_lzc};
    w_normMant = r_sum[24] ? r_sum[23:1] : (r_sum[22:0] << w_lzc);
    if (r_special)
      w_result = r_specialVal;
    else if (r_sum == 25'd0)
      w_result = 32'd0;
    else if (r_sum[24])
      w_result = (w_expInc >= 9'd255) ? {r_sumSign, 8'hFF, 23'd0}
                                      : {r_sumSign, w_expInc[7:0], w_normMant};
    else if ({3'b000, w_lzc} >= r_exp)
      w_result = {r_sumSign, 31'd0};
    else
      w_result = {r_sumSign, w_expDec, w_normMant};
  end

  // Control FSM together with every datapath register it sequences.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_inReady    <= 1'b0;
      r_outValid   <= 1'b0;
      r_last       <= 1'b0;
      r_special    <= 1'b0;
      r_signA      <= 1'b0;
      r_signB      <= 1'b0;
      r_sumSign    <= 1'b0;
      r_acc        <= 32'd0;
      r_term       <= 32'd0;
      r_specialVal <= 32'd0;
      r_count      <= '0;
      r_mantA      <= 24'd0;
      r_mantB      <= 24'd0;
      r_exp        <= 8'd0;
      r_sum        <= 25'd0;
    end else begin
      case (r_state)
        IDLE: begin
          r_inReady <= 1'b1;
          if (in_valid && r_inReady) begin
            r_term    <= in_data;
            r_last    <= in_last;
            r_inReady <= 1'b0;
            r_state   <= ALIGN;
            if (r_count != {CNT_W{1'b1}}) r_count <= r_count + CNT_W'(1);
          end
        end
        ALIGN: begin
          r_signA      <= r_acc[31];
          r_signB      <= r_term[31];
          r_mantA      <= w_alignA;
          r_mantB      <= w_alignB;
          r_exp        <= w_maxExp;
          r_special    <= w_special;
          r_specialVal <= w_specialVal;
          r_state      <= ADD;
        end
        ADD: begin
          r_sum     <= w_sum;
          r_sumSign <= w_sumSign;
          r_state   <= NORM;
        end
        NORM: begin
          r_acc <= w_result;
          if (r_last) begin
            r_outValid <= 1'b1;
            r_state    <= OUT;
          end else begin
            r_inReady <= 1'b1;
            r_state   <= IDLE;
          end
        end
        OUT: begin
          if (out_ready) begin
            r_outValid <= 1'b0;
            r_acc      <= 32'd0;
            r_count    <= '0;
            r_inReady  <= 1'b1;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = r_inReady;
  assign out_valid = r_outValid;
  assign out_data  = r_acc;
  assign out_count = r_count;

endmodule
